// File: rtl/demux2_pkg.sv
// Shared definitions for the 1:2 registered stream demultiplexer:
// default widths, select encoding and the per-slot state encoding.
package demux2_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 8;

    localparam logic SEL_SINK0 = 1'b0;
    localparam logic SEL_SINK1 = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/demux2_slot.sv
// One-entry valid/ready holding slot with a delivery counter.
// The slot accepts a new word while empty, or while full and draining in the
// same cycle, which gives one word per cycle through a non-stalled sink.
module demux2_slot
    import demux2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic             can_accept,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic [CNT_W-1:0] cnt
);

    slot_state_e state;
    logic        drain;

    assign valid      = (state == ST_FULL);
    assign drain      = valid & ready;
    // A full slot frees up on this edge when the sink takes its word, so it
    // can take the next one without a bubble.
    assign can_accept = (state == ST_EMPTY) | drain;

    // Slot FSM: EMPTY <-> FULL, data captured on every load and held while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            // NOTE: the data register is reset too, because the outputs must
            // read zero during reset rather than stale or undefined contents.
            data  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here samples the pre-edge values of state and data.
            case (state)
                ST_EMPTY: begin
                    if (load) begin
                        state <= ST_FULL;
                        data  <= load_data;
                    end
                end
                ST_FULL: begin
                    if (load) begin
                        data <= load_data;
                    end else if (drain) begin
                        state <= ST_EMPTY;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    // Delivery counter: one increment per completed handshake, wraps freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (drain) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/demux2_stream.sv
// 1:2 registered stream demultiplexer. Decodes in_sel into a load strobe for
// one of two holding slots and muxes that slot's accept condition to in_ready.
// in_ready never depends on in_valid, so upstream may wait on it freely.
module demux2_stream
    import demux2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic accept0;
    logic accept1;
    logic load0;
    logic load1;

    // in_valid gates both loads first, so a floating in_sel while idle
    // cannot reach either slot.
    assign in_ready = (in_sel == SEL_SINK1) ? accept1 : accept0;
    assign load0    = in_valid & in_ready & (in_sel == SEL_SINK0);
    assign load1    = in_valid & in_ready & (in_sel == SEL_SINK1);

    demux2_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load0),
        .load_data  (in_data),
        .can_accept (accept0),
        .data       (out0_data),
        .valid      (out0_valid),
        .ready      (out0_ready),
        .cnt        (cnt0)
    );

    demux2_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_slot1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load1),
        .load_data  (in_data),
        .can_accept (accept1),
        .data       (out1_data),
        .valid      (out1_valid),
        .ready      (out1_ready),
        .cnt        (cnt1)
    );

endmodule

// File: tb/tb_demux2_stream.sv
// Directed testbench for demux2_stream. Inputs are driven 1 ns after the
// rising edge and outputs are sampled there too, away from the active edge.
module tb_demux2_stream;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [7:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    int tests;
    int errors;

    demux2_stream #(.WIDTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        in_data    = 8'h00;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        #2;
        tests++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL reset_out0_valid: got %b want 0", out0_valid); end
        tests++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL reset_out1_valid: got %b want 0", out1_valid); end
        tests++; if (cnt0 !== 8'h00) begin errors++; $display("FAIL reset_cnt0: got %h want 00", cnt0); end
        tests++; if (cnt1 !== 8'h00) begin errors++; $display("FAIL reset_cnt1: got %h want 00", cnt1); end
        tests++; if (out0_data !== 8'h00) begin errors++; $display("FAIL reset_out0_data: got %h want 00", out0_data); end
        tests++; if (out1_data !== 8'h00) begin errors++; $display("FAIL reset_out1_data: got %h want 00", out1_data); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        in_data  = 8'hA5;
        in_sel   = 1'b0;
        in_valid = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tests++; if (out0_valid !== 1'b1) begin errors++; $display("FAIL single_out0_valid: got %b want 1", out0_valid); end
        tests++; if (out0_data !== 8'hA5) begin errors++; $display("FAIL single_out0_data: got %h want a5", out0_data); end
        tests++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL single_out1_valid: got %b want 0", out1_valid); end
        tests++; if (cnt0 !== 8'h00) begin errors++; $display("FAIL single_cnt0_early: got %h want 00", cnt0); end
        tick();
        tests++; if (cnt0 !== 8'h01) begin errors++; $display("FAIL single_cnt0: got %h want 01", cnt0); end
        tests++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL single_out0_drained: got %b want 0", out0_valid); end
        tests++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL single_out1_still: got %b want 0", out1_valid); end
    endtask

    task automatic test_stall();
        out1_ready = 1'b0;
        in_data    = 8'h3C;
        in_sel     = 1'b1;
        in_valid   = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_first_ready: got %b want 1", in_ready); end
        tick();
        in_data = 8'h77;
        #1;
        tests++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_second_ready: got %b want 0", in_ready); end
        tick();
        tests++; if (out1_data !== 8'h3C) begin errors++; $display("FAIL stall_hold_data: got %h want 3c", out1_data); end
        tests++; if (out1_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid: got %b want 1", out1_valid); end
        out1_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tests++; if (out1_data !== 8'h77) begin errors++; $display("FAIL stall_next_data: got %h want 77", out1_data); end
        tests++; if (out1_valid !== 1'b1) begin errors++; $display("FAIL stall_next_valid: got %b want 1", out1_valid); end
        tests++; if (cnt1 !== 8'h01) begin errors++; $display("FAIL stall_cnt1_mid: got %h want 01", cnt1); end
        tick();
        tests++; if (cnt1 !== 8'h02) begin errors++; $display("FAIL stall_cnt1: got %h want 02", cnt1); end
        tests++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL stall_out1_drained: got %b want 0", out1_valid); end
    endtask

    task automatic test_independent();
        out1_ready = 1'b0;
        in_data    = 8'h55;
        in_sel     = 1'b1;
        in_valid   = 1'b1;
        tick();
        in_data = 8'h11;
        in_sel  = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin errors++; $display("FAIL indep_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        tests++; if (out0_data !== 8'h11) begin errors++; $display("FAIL indep_out0_data: got %h want 11", out0_data); end
        tests++; if (out0_valid !== 1'b1) begin errors++; $display("FAIL indep_out0_valid: got %b want 1", out0_valid); end
        tests++; if (out1_data !== 8'h55) begin errors++; $display("FAIL indep_out1_data: got %h want 55", out1_data); end
        tests++; if (out1_valid !== 1'b1) begin errors++; $display("FAIL indep_out1_valid: got %b want 1", out1_valid); end
        tick();
        tests++; if (cnt0 !== 8'h02) begin errors++; $display("FAIL indep_cnt0: got %h want 02", cnt0); end
        tests++; if (cnt1 !== 8'h02) begin errors++; $display("FAIL indep_cnt1: got %h want 02", cnt1); end
        tests++; if (out1_data !== 8'h55) begin errors++; $display("FAIL indep_out1_kept: got %h want 55", out1_data); end
    endtask

    task automatic test_back_to_back();
        out0_ready = 1'b0;
        in_data    = 8'h01;
        in_sel     = 1'b0;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++; if (out0_data !== 8'h01) begin errors++; $display("FAIL b2b_first_data: got %h want 01", out0_data); end
        out0_ready = 1'b1;
        in_data    = 8'h02;
        in_valid   = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
        tick();
        tests++; if (out0_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", out0_valid); end
        tests++; if (out0_data !== 8'h02) begin errors++; $display("FAIL b2b_data: got %h want 02", out0_data); end
        tests++; if (cnt0 !== 8'h03) begin errors++; $display("FAIL b2b_cnt0: got %h want 03", cnt0); end
        for (int i = 3; i <= 5; i++) begin
            in_data = 8'(i);
            #1;
            tests++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_stream_ready_%0d: got %b want 1", i, in_ready); end
            tick();
            tests++; if (out0_data !== 8'(i)) begin errors++; $display("FAIL b2b_stream_data_%0d: got %h want %h", i, out0_data, 8'(i)); end
        end
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        tick();
        tests++; if (cnt0 !== 8'h06) begin errors++; $display("FAIL b2b_cnt0_final: got %h want 06", cnt0); end
        tests++; if (out0_data !== 8'h05) begin errors++; $display("FAIL b2b_held: got %h want 05", out0_data); end
    endtask

    task automatic test_async_reset();
        tests++; if ({out0_valid, out1_valid} !== 2'b11) begin errors++; $display("FAIL areset_pre_full: got %b want 11", {out0_valid, out1_valid}); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL areset_out0_valid: got %b want 0", out0_valid); end
        tests++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL areset_out1_valid: got %b want 0", out1_valid); end
        tests++; if (cnt0 !== 8'h00) begin errors++; $display("FAIL areset_cnt0: got %h want 00", cnt0); end
        tests++; if (cnt1 !== 8'h00) begin errors++; $display("FAIL areset_cnt1: got %h want 00", cnt1); end
        tests++; if (out0_data !== 8'h00) begin errors++; $display("FAIL areset_out0_data: got %h want 00", out0_data); end
        tick();
        rst_n      = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        tick();
        tests++; if ({out0_valid, out1_valid} !== 2'b00) begin errors++; $display("FAIL areset_resume_empty: got %b want 00", {out0_valid, out1_valid}); end
    endtask

    task automatic test_wrap();
        in_sel   = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tests++; if (cnt0 !== 8'hFF) begin errors++; $display("FAIL wrap_cnt0_ff: got %h want ff", cnt0); end
        tests++; if (out0_data !== 8'hFF) begin errors++; $display("FAIL wrap_last_data: got %h want ff", out0_data); end
        tick();
        tests++; if (cnt0 !== 8'h00) begin errors++; $display("FAIL wrap_cnt0_00: got %h want 00", cnt0); end
        tests++; if (cnt1 !== 8'h00) begin errors++; $display("FAIL wrap_cnt1: got %h want 00", cnt1); end
        tests++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL wrap_out1_valid: got %b want 0", out1_valid); end
    endtask

    task automatic test_idle_dont_care();
        in_valid = 1'b0;
        in_sel   = 1'bx;
        in_data  = 8'hxx;
        tick();
        tick();
        tests++; if ({out0_valid, out1_valid} !== 2'b00) begin errors++; $display("FAIL idle_valids: got %b want 00", {out0_valid, out1_valid}); end
        tests++; if (cnt0 !== 8'h00) begin errors++; $display("FAIL idle_cnt0: got %h want 00", cnt0); end
        tests++; if (out0_data !== 8'hFF) begin errors++; $display("FAIL idle_out0_data: got %h want ff", out0_data); end
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        test_reset();
        test_single();
        test_stall();
        test_independent();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        test_idle_dont_care();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
